// File: rtl/bsg_lane_scatter.sv
// Lane scatter: takes a lane mask, then popcount(mask) packed words (lowest active lane
// first), and presents them expanded into their lane positions as one sparse vector.
module bsg_lane_scatter #(
   parameter int width_p = 8,
   parameter int els_p   = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       mask_v_i,
   input  logic [els_p-1:0]           mask_i,
   output logic                       mask_ready_o,
   input  logic                       data_v_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       data_ready_o,
   output logic                       v_o,
   output logic [els_p*width_p-1:0]   data_o,
   output logic [els_p-1:0]           mask_o,
   input  logic                       yumi_i
);

   localparam int cnt_w_lp  = $clog2(els_p + 1);
   localparam int lane_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

   state_e                     state_q, state_d;
   logic [els_p-1:0]           mask_q, mask_d;
   logic [els_p*width_p-1:0]   data_q, data_d;
   logic [cnt_w_lp-1:0]        cnt_q, cnt_d;

   logic [cnt_w_lp-1:0]        popcnt;
   logic [cnt_w_lp-1:0]        seen;
   logic [lane_w_lp-1:0]       lane_sel;

   // Lane for the next word is the position of the cnt-th set bit of the latched mask.
   always_comb begin
      popcnt   = '0;
      seen     = '0;
      lane_sel = '0;
      for (int k = 0; k < els_p; k++) begin
         if (mask_q[k]) begin
            if (seen == cnt_q) lane_sel = lane_w_lp'(k);
            seen = seen + cnt_w_lp'(1);
         end
      end
      popcnt = seen;
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mask_v_i) begin
               mask_d  = mask_i;
               data_d  = '0;
               cnt_d   = '0;
               state_d = (mask_i == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (data_v_i) begin
               for (int k = 0; k < els_p; k++) begin
                  if (lane_sel == lane_w_lp'(k)) data_d[k*width_p +: width_p] = data_i;
               end
               cnt_d = cnt_q + cnt_w_lp'(1);
               if (cnt_q + cnt_w_lp'(1) == popcnt) state_d = DONE;
            end
         end
         DONE: begin
            if (yumi_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mask_ready_o = (state_q == IDLE);
   assign data_ready_o = (state_q == COLLECT);
   assign v_o          = (state_q == DONE);
   assign data_o       = data_q;
   assign mask_o       = mask_q;

endmodule

// File: tb/tb_bsg_lane_scatter.sv
// Directed and randomized bench for bsg_lane_scatter (width_p=8, els_p=4).
module tb_bsg_lane_scatter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mask_v = 1'b0;
   logic [3:0]  mask = '0;
   logic        mask_ready;
   logic        data_v = 1'b0;
   logic [7:0]  data = '0;
   logic        data_ready;
   logic        v;
   logic [31:0] dout;
   logic [3:0]  mout;
   logic        yumi = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   bsg_lane_scatter #(.width_p(8), .els_p(4)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .mask_v_i(mask_v), .mask_i(mask), .mask_ready_o(mask_ready),
      .data_v_i(data_v), .data_i(data), .data_ready_o(data_ready),
      .v_o(v), .data_o(dout), .mask_o(mout), .yumi_i(yumi)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n) assert (!(yumi && !v)) else $error("yumi_i asserted while v_o=0");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_mask(input logic [3:0] m);
      mask_v = 1'b1;
      mask   = m;
      for (int i = 0; i < 50 && !mask_ready; i++) step();
      if (!mask_ready) chk("mask_ready_timeout", mask_ready, 1);
      step();
      mask_v = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      data_v = 1'b0;
      repeat (gap) step();
      data_v = 1'b1;
      data   = w;
      for (int i = 0; i < 50 && !data_ready; i++) step();
      if (!data_ready) chk("data_ready_timeout", data_ready, 1);
      step();
      data_v = 1'b0;
   endtask

   task automatic pop();
      for (int i = 0; i < 50 && !v; i++) step();
      if (!v) chk("v_timeout", v, 1);
      yumi = 1'b1;
      step();
      yumi = 1'b0;
   endtask

   initial begin
      logic [3:0]  rm;
      logic [7:0]  rw [4];
      logic [31:0] rexp;
      int          idx;

      repeat (3) step();
      chk("rst_v", v, 0);
      chk("rst_data", dout, 0);
      chk("rst_mask", mout, 0);
      reset_n = 1'b1;
      step();
      chk("rst_mask_ready", mask_ready, 1);
      chk("rst_data_ready", data_ready, 0);

      // Test 1: mask+data together in IDLE, only the mask is taken
      mask_v = 1'b1; mask = 4'b1010; data_v = 1'b1; data = 8'hEE;
      step();
      mask_v = 1'b0; data_v = 1'b0;
      chk("t1_collect_ready", data_ready, 1);
      chk("t1_mask_ready", mask_ready, 0);
      send_word(8'hAA, 0);
      chk("t1_v_mid", v, 0);
      send_word(8'hBB, 0);
      chk("t1_v", v, 1);
      chk("t1_data", dout, 32'hBB00_AA00);
      chk("t1_mask", mout, 4'b1010);
      pop();
      chk("t1_v_drop", v, 0);
      chk("t1_idle", mask_ready, 1);

      // Test 2: empty mask
      send_mask(4'b0000);
      chk("t2_data_ready", data_ready, 0);
      chk("t2_v", v, 1);
      chk("t2_data", dout, 0);
      pop();

      // Test 3: all-ones with gaps
      send_mask(4'b1111);
      send_word(8'h11, 2);
      send_word(8'h22, 2);
      send_word(8'h33, 2);
      chk("t3_v_mid", v, 0);
      send_word(8'h44, 2);
      chk("t3_v", v, 1);
      chk("t3_data", dout, 32'h4433_2211);
      pop();

      // Test 4: hold in DONE with ignored traffic
      send_mask(4'b0110);
      send_word(8'h5A, 0);
      send_word(8'hC3, 0);
      mask_v = 1'b1; mask = 4'hF; data_v = 1'b1; data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_data", dout, 32'h00C3_5A00);
         chk("t4_mask", mout, 4'b0110);
         chk("t4_v", v, 1);
         chk("t4_rdy", {mask_ready, data_ready}, 2'b00);
      end
      mask_v = 1'b0; data_v = 1'b0;
      yumi = 1'b1;
      step();
      yumi = 1'b0;
      chk("t4_v_drop", v, 0);
      chk("t4_idle", mask_ready, 1);

      // Test 5: async reset mid-collect
      send_mask(4'b0111);
      send_word(8'h12, 0);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_v", v, 0);
      chk("t5_data", dout, 0);
      chk("t5_mask", mout, 0);
      chk("t5_data_ready", data_ready, 0);
      step();
      reset_n = 1'b1;
      step();
      chk("t5_mask_ready", mask_ready, 1);
      send_mask(4'b0001);
      send_word(8'h77, 0);
      chk("t5_v2", v, 1);
      chk("t5_data2", dout, 32'h0000_0077);
      pop();

      // Test 6: random masks, words and stalls against a reference scatter
      for (int t = 0; t < 1000; t++) begin
         rm = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) rw[k] = 8'($urandom_range(0, 255));
         rexp = '0;
         idx  = 0;
         for (int k = 0; k < 4; k++) begin
            if (rm[k]) begin
               rexp[k*8 +: 8] = rw[idx];
               idx++;
            end
         end
         send_mask(rm);
         for (int k = 0; k < idx; k++) send_word(rw[k], $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) step();
         chk("t6_v", v, 1);
         chk("t6_data", dout, rexp);
         chk("t6_mask", mout, rm);
         pop();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
